// File: rtl/spi_controller.sv
// Mode-0 SPI initiator that sends 16-bit {rw, addr, data} register frames MSB first
// and returns the low byte of CIPO for read frames.
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_GAP   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SCLK,
    output logic       nCS,
    output logic       COPI,
    input  logic       CIPO
);

    localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_CNT = (MAX_AB > CS_GAP) ? MAX_AB : CS_GAP;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DIV_LOAD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] phase_cnt;
    logic [15:0]   tx_shift;
    logic [7:0]    rx_shift;
    logic [4:0]    bit_cnt;
    logic          frame_rw;
    logic [1:0]    cipo_sync;

    // CIPO comes from another clock domain (the peripheral), so it is double-registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo_sync <= 2'b00;
        end else begin
            cipo_sync <= {cipo_sync[0], CIPO};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            frame_rw  <= 1'b0;
            nCS       <= 1'b1;
            SCLK      <= 1'b0;
            COPI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tx_shift  <= {cmd_rw, cmd_addr, cmd_data};
                        frame_rw  <= cmd_rw;
                        COPI      <= cmd_rw;
                        nCS       <= 1'b0;
                        bit_cnt   <= '0;
                        phase_cnt <= SETUP_LOAD;
                        state     <= SETUP;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                SETUP: begin
                    if (phase_cnt == '0) begin
                        SCLK      <= 1'b1;
                        phase_cnt <= DIV_LOAD;
                        state     <= HIGH;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                HIGH: begin
                    // Sample once per bit, on the first cycle SCLK is high.
                    if (phase_cnt == DIV_LOAD) begin
                        rx_shift <= {rx_shift[6:0], cipo_sync[1]};
                        bit_cnt  <= bit_cnt + 5'd1;
                    end
                    if (phase_cnt == '0) begin
                        SCLK      <= 1'b0;
                        phase_cnt <= DIV_LOAD;
                        state     <= LOW;
                        tx_shift  <= {tx_shift[14:0], 1'b0};
                        COPI      <= (bit_cnt == 5'd16) ? 1'b0 : tx_shift[14];
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                LOW: begin
                    if (phase_cnt == '0) begin
                        if (bit_cnt == 5'd16) begin
                            nCS       <= 1'b1;
                            phase_cnt <= GAP_LOAD;
                            state     <= GAP;
                            rsp_valid <= ~frame_rw;
                            if (!frame_rw) begin
                                rsp_data <= rx_shift;
                            end
                        end else begin
                            SCLK      <= 1'b1;
                            phase_cnt <= DIV_LOAD;
                            state     <= HIGH;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                GAP: begin
                    if (phase_cnt == '0) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: default instance plus a CLK_DIV=2/CS_SETUP=1 instance,
// observed through one pin monitor selected by 'sel'.
module tb_spi_controller;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cipo = 1'b0;
    logic       sel = 1'b0;

    logic       ready0, rsp_valid0, busy0, sclk0, ncs0, copi0;
    logic [7:0] rsp_data0;
    logic       ready1, rsp_valid1, busy1, sclk1, ncs1, copi1;
    logic [7:0] rsp_data1;

    logic       m_ready, m_rsp_valid, m_busy, m_sclk, m_ncs, m_copi;
    logic [7:0] m_rsp_data;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t exp_q[$];
    exp_t cur;
    logic in_frame = 1'b0;
    logic aborting = 1'b0;
    logic [15:0] bits = '0;
    int   nbits = 0;
    int   low_len = 0;
    int   cyc = 0;
    int   last_sclk_rise = 0;
    int   last_rise = 0;
    int   last_fall = 0;
    int   frames_done = 0;
    int   rsp_count = 0;
    logic prev_ncs = 1'b1;
    logic prev_sclk = 1'b0;
    logic prev_copi = 1'b0;

    always #5 clk = ~clk;

    spi_controller dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready0),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0),
        .SCLK(sclk0), .nCS(ncs0), .COPI(copi0), .CIPO(cipo)
    );

    spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_GAP(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready1),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1),
        .SCLK(sclk1), .nCS(ncs1), .COPI(copi1), .CIPO(cipo)
    );

    assign m_ready     = sel ? ready1 : ready0;
    assign m_rsp_valid = sel ? rsp_valid1 : rsp_valid0;
    assign m_rsp_data  = sel ? rsp_data1 : rsp_data0;
    assign m_busy      = sel ? busy1 : busy0;
    assign m_sclk      = sel ? sclk1 : sclk0;
    assign m_ncs       = sel ? ncs1 : ncs0;
    assign m_copi      = sel ? copi1 : copi0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pin-level monitor: rebuilds each frame, plays the peripheral on CIPO and checks timing.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame  = 1'b0;
            aborting  = 1'b0;
            prev_ncs  = 1'b1;
            prev_sclk = 1'b0;
            prev_copi = 1'b0;
            cipo      = 1'b0;
        end else begin
            if (prev_ncs && !m_ncs) begin
                last_fall = cyc;
                bits = '0;
                nbits = 0;
                low_len = 0;
                cipo = 1'b0;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame", 32'd1, 32'd0);
                    in_frame = 1'b0;
                end else begin
                    cur = exp_q[0];
                    in_frame = 1'b1;
                end
            end
            if (!m_ncs) begin
                low_len++;
                if (!prev_sclk && m_sclk) begin
                    checkOutput("copi_stable", {31'd0, m_copi}, {31'd0, prev_copi});
                    if (nbits > 0) begin
                        checkOutput("sclk_period", cyc - last_sclk_rise, sel ? 32'd4 : 32'd8);
                    end
                    last_sclk_rise = cyc;
                    bits = {bits[14:0], m_copi};
                    nbits++;
                end
                if (prev_sclk && !m_sclk) begin
                    cipo = (in_frame && nbits >= 8 && nbits < 16) ? cur.rdata[15-nbits] : 1'b0;
                end
            end
            if (!prev_ncs && m_ncs) begin
                last_rise = cyc;
                cipo = 1'b0;
                if (aborting) begin
                    aborting = 1'b0;
                end else if (in_frame) begin
                    void'(exp_q.pop_front());
                    checkOutput("frame_bits", {16'd0, bits}, {16'd0, cur.frame});
                    checkOutput("frame_nbits", nbits, 32'd16);
                    checkOutput("ncs_low_len", low_len, sel ? 32'd65 : 32'd132);
                    checkOutput("rsp_valid_at_rise", {31'd0, m_rsp_valid}, {31'd0, ~cur.frame[15]});
                    if (!cur.frame[15]) begin
                        checkOutput("rsp_data", {24'd0, m_rsp_data}, {24'd0, cur.rdata});
                    end
                    frames_done++;
                end
                in_frame = 1'b0;
            end else if (m_rsp_valid) begin
                checkOutput("rsp_stray", 32'd1, 32'd0);
            end
            if (m_rsp_valid) begin
                rsp_count++;
            end
            prev_ncs  = m_ncs;
            prev_sclk = m_sclk;
            prev_copi = m_copi;
        end
    end

    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                                 input logic [7:0] rbyte, input logic hold);
        exp_t e;
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        e.frame = {rw, addr, data};
        e.rdata = rbyte;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("idle_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int first_rise;
        int frames_before;
        int rsp_before;
        bit ok;

        repeat (3) @(negedge clk);
        checkOutput("reset_ncs", {31'd0, m_ncs}, 32'd1);
        checkOutput("reset_sclk", {31'd0, m_sclk}, 32'd0);
        checkOutput("reset_copi", {31'd0, m_copi}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        checkOutput("reset_rsp_data", {24'd0, m_rsp_data}, 32'd0);
        checkOutput("reset_busy", {31'd0, m_busy}, 32'd0);
        checkOutput("reset_ready", {31'd0, m_ready}, 32'd1);
        rst_n = 1'b1;

        applyStimulus(1'b1, 7'h00, 8'hA5, 8'h00, 1'b0);
        waitIdle();

        rsp_before = rsp_count;
        applyStimulus(1'b0, 7'h04, 8'h00, 8'h3C, 1'b0);
        waitIdle();
        repeat (5) @(negedge clk);
        checkOutput("read_pulse_count", rsp_count - rsp_before, 32'd1);
        checkOutput("read_data_held", {24'd0, m_rsp_data}, 32'h3C);

        // Back-to-back with cmd_valid held high.
        applyStimulus(1'b1, 7'h01, 8'hFF, 8'h00, 1'b1);
        applyStimulus(1'b1, 7'h02, 8'h0F, 8'h00, 1'b0);
        first_rise = last_rise;
        @(negedge clk);
        #1;
        checkOutput("b2b_gap", last_fall - first_rise, 32'd9);
        waitIdle();

        // Input churn during a frame must not disturb it.
        frames_before = frames_done;
        applyStimulus(1'b1, 7'h10, 8'h33, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            repeat (30) @(negedge clk);
            cmd_data  = 8'hCC;
            cmd_valid = 1'b1;
            #1;
            checkOutput("midframe_ready", {31'd0, m_ready}, 32'd0);
            checkOutput("midframe_busy", {31'd0, m_busy}, 32'd1);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        waitIdle();
        repeat (30) @(negedge clk);
        checkOutput("no_extra_frame", frames_done - frames_before, 32'd1);

        // Reset in the middle of a read frame.
        rsp_before = rsp_count;
        applyStimulus(1'b0, 7'h20, 8'h00, 8'hFF, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (nbits == 5 && !m_ncs) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("fifth_rise_seen", {31'd0, ok}, 32'd1);
        aborting = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ncs", {31'd0, m_ncs}, 32'd1);
        checkOutput("abort_sclk", {31'd0, m_sclk}, 32'd0);
        checkOutput("abort_copi", {31'd0, m_copi}, 32'd0);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 7'h00, 8'h5A, 8'h00, 1'b0);
        waitIdle();
        checkOutput("abort_no_rsp", rsp_count - rsp_before, 32'd0);

        // Fast instance: CLK_DIV=2, CS_SETUP=1.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 7'h05, 8'h96, 8'h00, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 7'h06, 8'h00, 8'hE1, 1'b0);
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("fast_read_held", {24'd0, m_rsp_data}, 32'hE1);
        checkOutput("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
